// File: rtl/addr_sweep_sched.sv
// ============================================================================
//  Module   : addr_sweep_sched
//  Purpose  : Round-robin arbitrated 2-D address sweep generator with a
//             valid/ready address stream, sticky wrap detection and done pulse.
//             Optional macro ADDR_SWEEP_SCHED_OVF_STOP_EN ends the sweep on
//             the first wrapped beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_sweep_sched #(
    parameter int ROWS       = 6,
    parameter int COLS       = 4,
    parameter int ROW_STRIDE = 4,
    parameter int COL_STRIDE = 1,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [AW-1:0] addr,
    output logic          addr_last,
    output logic          overflow,
    output logic          done,
    output logic          done_id
);

    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW-1:0] ROW_STEP = AW'(ROW_STRIDE);
    localparam logic [AW-1:0] COL_STEP = AW'(COL_STRIDE);
    localparam logic [IW-1:0] I_LAST   = IW'(ROWS - 1);
    localparam logic [JW-1:0] J_LAST   = JW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IW-1:0] row_idx;
    logic [JW-1:0] col_idx;
    logic [AW-1:0] row_addr;
    logic [AW-1:0] cur_addr;
    logic          row_hi;
    logic          beat_hi;
    logic          ovf;
    logic          owner;
    logic          rr_ptr;

    logic          start;
    logic          pick;
    logic [AW-1:0] base_sel;
    logic          beat_fire;
    logic          pos_last;
    logic          is_last;
    logic [AW:0]   col_sum;
    logic [AW:0]   row_sum;

    assign start     = (state == IDLE) && (req != 2'b00);
    assign pick      = (req == 2'b11) ? rr_ptr : req[1];
    assign base_sel  = pick ? base1 : base0;
    assign beat_fire = (state == RUN) && addr_ready;
    assign pos_last  = (row_idx == I_LAST) && (col_idx == J_LAST);

`ifdef ADDR_SWEEP_SCHED_OVF_STOP_EN
    assign is_last = pos_last || beat_hi;
`else
    assign is_last = pos_last;
`endif

    // Carry bits of the incremental adders mark beats whose untruncated sum wrapped.
    assign col_sum = {1'b0, cur_addr} + {1'b0, COL_STEP};
    assign row_sum = {1'b0, row_addr} + {1'b0, ROW_STEP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req != 2'b00) state_next = RUN;
            RUN:     if (addr_ready && is_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx  <= '0;
            col_idx  <= '0;
            row_addr <= '0;
            cur_addr <= '0;
            row_hi   <= 1'b0;
            beat_hi  <= 1'b0;
            ovf      <= 1'b0;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            if (start) begin
                owner    <= pick;
                row_addr <= base_sel;
                cur_addr <= base_sel;
                row_idx  <= '0;
                col_idx  <= '0;
                row_hi   <= 1'b0;
                beat_hi  <= 1'b0;
                ovf      <= 1'b0;
            end else if (beat_fire && !is_last) begin
                if (col_idx != J_LAST) begin
                    col_idx  <= col_idx + JW'(1);
                    cur_addr <= col_sum[AW-1:0];
                    beat_hi  <= beat_hi | col_sum[AW];
                    ovf      <= ovf | beat_hi | col_sum[AW];
                end else begin
                    // A new row restarts from the row origin, which may not have wrapped yet.
                    col_idx  <= '0;
                    row_idx  <= row_idx + IW'(1);
                    row_addr <= row_sum[AW-1:0];
                    cur_addr <= row_sum[AW-1:0];
                    row_hi   <= row_hi | row_sum[AW];
                    beat_hi  <= row_hi | row_sum[AW];
                    ovf      <= ovf | row_hi | row_sum[AW];
                end
            end
            if (state == DONE) begin
                rr_ptr <= ~owner;
            end
        end
    end

    assign grant      = (state == RUN) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);
    assign addr_valid = (state == RUN);
    assign addr       = cur_addr;
    assign addr_last  = (state == RUN) && is_last;
    assign overflow   = ovf;
    assign done       = (state == DONE);
    assign done_id    = (state == DONE) && owner;

endmodule

`default_nettype wire

// File: tb/tb_addr_sweep_sched.sv
// Directed bench for addr_sweep_sched: default-width instance plus an AW=8
// instance for the address-wrap scenario.
`timescale 1ns/1ps
`default_nettype none

module tb_addr_sweep_sched;

    localparam int COLS = 4;
    localparam int NB   = 24;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req;
    logic [31:0] base0, base1;
    logic        addr_ready;

    logic [1:0]  grant;
    logic        busy, addr_valid, addr_last, overflow, done, done_id;
    logic [31:0] addr;

    logic [7:0]  base0_8, base1_8, addr_8;
    logic [1:0]  grant_8;
    logic        busy_8, addr_valid_8, addr_last_8, overflow_8, done_8, done_id_8;

    int n_checks = 0;
    int n_fail   = 0;

    addr_sweep_sched dut (
        .clk(clk), .rst(rst), .req(req), .base0(base0), .base1(base1),
        .grant(grant), .busy(busy), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr(addr), .addr_last(addr_last), .overflow(overflow), .done(done), .done_id(done_id)
    );

    addr_sweep_sched #(.AW(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .base0(base0_8), .base1(base1_8),
        .grant(grant_8), .busy(busy_8), .addr_valid(addr_valid_8), .addr_ready(addr_ready),
        .addr(addr_8), .addr_last(addr_last_8), .overflow(overflow_8), .done(done_8), .done_id(done_id_8)
    );

    // Expects the first RUN cycle to be visible at the current negedge.
    task automatic run_sweep(input logic [31:0] b, input logic id, input bit stall, input string tag);
        int beat = 0;
        int cyc  = 0;
        logic [31:0] exp_a;
        logic [1:0]  exp_g;
        exp_g = id ? 2'b10 : 2'b01;
        while (beat < NB && cyc < 400) begin
            addr_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            exp_a = b + 32'((beat / COLS) * 4 + (beat % COLS));
            n_checks++;
            if (addr_valid !== 1'b1 || addr !== exp_a || grant !== exp_g || addr_last !== (beat == NB - 1)) begin
                n_fail++;
                $display("FAIL %s beat %0d: valid=%b addr=%h grant=%b last=%b, expected valid=1 addr=%h grant=%b last=%b",
                         tag, beat, addr_valid, addr, grant, addr_last, exp_a, exp_g, beat == NB - 1);
            end
            if (addr_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        addr_ready = 1'b1;
        n_checks++;
        if (beat != NB || done !== 1'b1 || done_id !== id || addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: beats=%0d done=%b done_id=%b valid=%b, expected beats=%0d done=1 done_id=%b valid=0",
                     tag, beat, done, done_id, addr_valid, NB, id);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; addr_ready = 1'b1;
        base0 = '0; base1 = '0; base0_8 = '0; base1_8 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({grant, busy, addr_valid, addr, addr_last, overflow, done, done_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b busy=%b valid=%b addr=%h last=%b ovf=%b done=%b id=%b, expected all 0",
                     grant, busy, addr_valid, addr, addr_last, overflow, done, done_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        req = 2'b01; base0 = 32'h100;
        @(negedge clk);
        req = 2'b00;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b, expected 1", busy);
        end
        run_sweep(32'h100, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 2'b11; base0 = 32'h100; base1 = 32'h400;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            if (s == 2) req = 2'b00;
            run_sweep((s == 1) ? 32'h400 : 32'h100, (s == 1), 1'b0, "b2b");
            if (s < 2) begin
                @(negedge clk);
                n_checks++;
                if (addr_valid !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_gap %0d: valid=%b done=%b, expected 0 0", s, addr_valid, done);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_stall();
        repeat (2) @(negedge clk);
        req = 2'b01; base0 = 32'h100;
        @(negedge clk);
        req = 2'b00;
        run_sweep(32'h100, 1'b0, 1'b1, "stall");
    endtask

    task automatic test_mid_reset();
        repeat (2) @(negedge clk);
        req = 2'b01; base0 = 32'h200;
        @(negedge clk);
        req = 2'b00;
        repeat (10) @(negedge clk);
        n_checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h20A) begin
            n_fail++;
            $display("FAIL midrst_beat10: valid=%b addr=%h, expected 1 0000020a", addr_valid, addr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, busy, addr_valid, addr, addr_last, overflow, done, done_id} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: grant=%b busy=%b valid=%b addr=%h last=%b ovf=%b done=%b id=%b, expected all 0",
                     grant, busy, addr_valid, addr, addr_last, overflow, done, done_id);
        end
        rst = 1'b0; req = 2'b10; base1 = 32'h300;
        @(negedge clk);
        req = 2'b00;
        run_sweep(32'h300, 1'b1, 1'b0, "midrst_new");
    endtask

    task automatic test_overflow();
        int beat = 0;
        int cyc  = 0;
        int nexp;
        logic [7:0] exp_a;
`ifdef ADDR_SWEEP_SCHED_OVF_STOP_EN
        nexp = 17;
`else
        nexp = 24;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 2'b10; base1_8 = 8'hF0;
        @(negedge clk);
        req = 2'b00;
        n_checks++;
        if (grant_8 !== 2'b10 || busy_8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_grant: grant=%b busy=%b, expected 10 1", grant_8, busy_8);
        end
        while (beat < nexp && cyc < 200) begin
            addr_ready = 1'b1;
            exp_a = 8'(240 + (beat / 4) * 4 + (beat % 4));
            n_checks++;
            if (addr_valid_8 !== 1'b1 || addr_8 !== exp_a || overflow_8 !== (beat >= 16) || addr_last_8 !== (beat == nexp - 1)) begin
                n_fail++;
                $display("FAIL ovf beat %0d: valid=%b addr=%h ovf=%b last=%b, expected valid=1 addr=%h ovf=%b last=%b",
                         beat, addr_valid_8, addr_8, overflow_8, addr_last_8, exp_a, beat >= 16, beat == nexp - 1);
            end
            beat++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (beat != nexp || done_8 !== 1'b1 || done_id_8 !== 1'b1 || overflow_8 !== 1'b1 || addr_valid_8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_end: beats=%0d done=%b id=%b ovf=%b valid=%b, expected beats=%0d done=1 id=1 ovf=1 valid=0",
                     beat, done_8, done_id_8, overflow_8, addr_valid_8, nexp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/addr_sweep_sched.md
ADDR_SWEEP_SCHED -- requirements
Module: addr_sweep_sched

Interface
REQ-001 SHALL have parameter ROWS, default 6, meaning outer loop count i (0..ROWS-1).
REQ-002 SHALL have parameter COLS, default 4, meaning inner loop count j (0..COLS-1).
REQ-003 SHALL have parameter ROW_STRIDE, default 4, meaning address increment per i step.
REQ-004 SHALL have parameter COL_STRIDE, default 1, meaning address increment per j step.
REQ-005 SHALL have parameter AW, default 32, meaning address width.
REQ-006 SHALL have ports, one per line:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- req  in  2  per-requester sweep request.
- base0  in  AW  start address for requester 0.
- base1  in  AW  start address for requester 1.
- grant  out  2  one-hot owner of the current sweep.
- busy  out  1  sweep in progress.
- addr_valid  out  1  addr holds a valid beat.
- addr_ready  in  1  consumer accepts the beat.
- addr  out  AW  current address.
- addr_last  out  1  final beat of the sweep.
- overflow  out  1  sticky; sweep produced a wrapped address.
- done  out  1  one-cycle end-of-sweep pulse.
- done_id  out  1  requester index that finished; valid with done.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, DONE.
REQ-008 IDLE: if req!=0, SHALL pick one requester round-robin (priority to the one not served last; both pending with no history -> 0), latch its base, clear i, j and overflow, set grant, and enter RUN the next cycle.
REQ-009 SHALL assert grant, busy and addr_valid in the first RUN cycle, i.e. one cycle after req is sampled in IDLE.
REQ-010 RUN: addr SHALL equal base + i*ROW_STRIDE + j*COL_STRIDE, truncated to AW bits and computed incrementally (no multiplier).
REQ-011 addr, addr_valid and addr_last SHALL hold stable while addr_valid=1 and addr_ready=0.
REQ-012 On addr_valid&&addr_ready: if j<COLS-1, j SHALL increment; else j SHALL clear and i SHALL increment.
REQ-013 addr_last SHALL be 1 only on beat i=ROWS-1, j=COLS-1 (or per REQ-021).
REQ-014 Handshake on the last beat SHALL move the FSM to DONE; addr_valid SHALL drop in the next cycle.
REQ-015 DONE: done=1 and done_id=owner for exactly one cycle; grant SHALL clear; round-robin pointer SHALL update; next state SHALL be IDLE.
REQ-016 A sweep SHALL yield exactly ROWS*COLS beats, with at most one beat per cycle.
REQ-017 overflow SHALL set on the first beat whose untruncated sum is >= 2^AW, stay set until the next sweep starts, and be readable in DONE.
REQ-018 req changes during RUN/DONE SHALL be ignored; a sweep never aborts. A req held through DONE SHALL be arbitrated in the following IDLE cycle.
REQ-019 Minimum gap between sweeps SHALL be 2 cycles (DONE, IDLE).

Reset
REQ-020 When rst=1 at a clock edge in any state, including mid-sweep, the block SHALL:
- enter IDLE;
- clear i, j and the round-robin pointer (requester 0 favoured);
- drive grant, busy, addr_valid, addr, addr_last, overflow, done and done_id to 0 from the next cycle.

Configuration
REQ-021 With macro ADDR_SWEEP_SCHED_OVF_STOP_EN defined, the first beat that sets overflow SHALL carry addr_last=1, and its handshake SHALL end the sweep (enter DONE).
REQ-022 With ADDR_SWEEP_SCHED_OVF_STOP_EN undefined, the sweep SHALL always run all ROWS*COLS beats; overflow is report-only.

Verification
REQ-023 Benches SHALL cover the following directed scenarios:
- Defaults, req=01, base0=0x100, addr_ready=1 -> 24 beats 0x100,0x101,0x102,0x103,0x104..0x117; addr_last on 0x117; done=1, done_id=0 the next cycle.
- req=11 held continuously -> grant sequence 01,10,01; each sweep 24 beats; 2-cycle gap between sweeps.
- addr_ready toggled 1,0,0,1 -> addr stable while stalled; still 24 beats; no beat dropped or duplicated.
- AW=8, base1=0xF0, req=10 -> beat 0xFF followed by 0x00 sets overflow. Without macro: 24 beats, overflow=1 at done. With macro: sweep ends at the wrapping beat with addr_last=1.
- rst=1 at beat 10 of a sweep -> next cycle all outputs 0, state IDLE; new req=10 -> grant=10 and a fresh sweep from base1.
